// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed 7-segment scanner with double-buffered display data
// Optional feature macro: SEG7_SCAN_DIM_EN (adds dim input and PWM brightness control)
module seg7_scan #(
   parameter int DIGIT_CYCLES = 25000,
   parameter int BLANK_CYCLES = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg0,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   input  logic [3:0] dp,
   input  logic       load,
`ifdef SEG7_SCAN_DIM_EN
   input  logic [2:0] dim,
`endif
   output logic [3:0] io_sel,
   output logic [7:0] io_seg,
   output logic       frame_tick
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_ON    = 1'b1;

   logic [CW-1:0]   cnt, cnt_next;
   logic [1:0]      idx, idx_next;
   logic [0:0]      state, state_next;
   logic            wrap;

   logic [3:0][6:0] shadow_seg, disp_seg;
   logic [3:0]      shadow_dp, disp_dp;
   logic            pending;

   logic            lit_next;
   logic [3:0]      sel_next;
   logic [7:0]      seg_next;

   assign wrap       = (cnt == CNT_LAST);
   // The boundary is the final cycle of digit 3; derived from registers only.
   assign frame_tick = wrap && (idx == 2'd3);

   // Next slot position; outputs are registered from these so they line up with the counter.
   always_comb begin
      cnt_next   = wrap ? '0 : cnt + 1'b1;
      idx_next   = wrap ? idx + 2'd1 : idx;
      state_next = (cnt_next < CNT_BLANK) ? ST_BLANK : ST_ON;
   end

   // Slot counter, digit index and BLANK/ON state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         idx   <= 2'd0;
         state <= ST_BLANK;
      end else begin
         cnt   <= cnt_next;
         idx   <= idx_next;
         state <= state_next;
      end
   end

   // Shadow capture on load; pending survives a boundary that coincides with a new load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_seg <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
      end else begin
         if (load) begin
            shadow_seg <= {seg3, seg2, seg1, seg0};
            shadow_dp  <= dp;
         end
         if (load)
            pending <= 1'b1;
         else if (frame_tick)
            pending <= 1'b0;
      end
   end

   // Display registers change only at the frame boundary, so a frame never mixes two loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_seg <= '0;
         disp_dp  <= '0;
      end else if (frame_tick && pending) begin
         disp_seg <= shadow_seg;
         disp_dp  <= shadow_dp;
      end
   end

`ifdef SEG7_SCAN_DIM_EN
   logic [2:0] pwm_cnt, pwm_next;

   assign pwm_next = pwm_cnt + 3'd1;

   // Free-running PWM phase for brightness control.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pwm_cnt <= 3'd0;
      else
         pwm_cnt <= pwm_next;
   end

   assign lit_next = (state_next == ST_ON) && (pwm_next <= dim);
`else
   assign lit_next = (state_next == ST_ON);
`endif

   // Pattern for the upcoming cycle; the first ON cycle always follows a BLANK cycle,
   // so disp_* is already settled after a boundary transfer.
   always_comb begin
      sel_next = 4'hF;
      seg_next = 8'hFF;
      if (lit_next) begin
         sel_next = ~(4'b0001 << idx_next);
         seg_next = ~{disp_dp[idx_next], disp_seg[idx_next]};
      end
   end

   // Registered pad drivers, forced dark while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         io_sel <= 4'hF;
         io_seg <= 8'hFF;
      end else begin
         io_sel <= sel_next;
         io_seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized self-checking bench for seg7_scan against a frame-level model
module tb_seg7_scan;

   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * DC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg0 = '0, seg1 = '0, seg2 = '0, seg3 = '0;
   logic [3:0] dp = '0;
   logic       load = 1'b0;
   logic [3:0] io_sel;
   logic [7:0] io_seg;
   logic       frame_tick;

   seg7_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg0       (seg0),
      .seg1       (seg1),
      .seg2       (seg2),
      .seg3       (seg3),
      .dp         (dp),
      .load       (load),
      .io_sel     (io_sel),
      .io_seg     (io_seg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          t;
      logic [27:0] s;
      logic [3:0]  d;
   } ld_t;

   ld_t lq[$];
   int  t;
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   // A frame shows the newest load made at least two cycles before its start:
   // the boundary cycle itself still transfers the older shadow.
   task automatic model(input int tt, output logic [3:0] es, output logic [7:0] eg, output logic et);
      int          f, dg, pos;
      logic [27:0] s;
      logic [3:0]  d;
      f   = tt / FRAME;
      dg  = (tt / DC) % 4;
      pos = tt % DC;
      s   = '0;
      d   = '0;
      foreach (lq[i])
         if (lq[i].t <= FRAME * f - 2) begin
            s = lq[i].s;
            d = lq[i].d;
         end
      et = ((tt % FRAME) == FRAME - 1);
      if (pos < BC) begin
         es = 4'hF;
         eg = 8'hFF;
      end else begin
         es = ~(4'b0001 << dg);
         eg = ~{d[dg], s[dg*7 +: 7]};
      end
   endtask

   task automatic check_outputs();
      logic [3:0] es;
      logic [7:0] eg;
      logic       et;
      model(t, es, eg, et);
      chk("io_sel", {28'd0, io_sel}, {28'd0, es});
      chk("io_seg", {24'd0, io_seg}, {24'd0, eg});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, et});
   endtask

   // Drive one cycle (optionally with a load), advance past the edge and compare.
   task automatic cycle(input bit ld, input logic [27:0] s, input logic [3:0] d);
      load = ld;
      {seg3, seg2, seg1, seg0} = s;
      dp = d;
      if (ld) lq.push_back('{t: t, s: s, d: d});
      @(posedge clk);
      #1;
      t++;
      load = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 28'd0, 4'd0);
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 9) == 0 || ((t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1))
            cycle(1'b1, 28'($urandom), 4'($urandom));
         else
            cycle(1'b0, 28'($urandom), 4'($urandom));
      end
   endtask

   initial begin
      int t0, tgt;
      t = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", {28'd0, io_sel}, 32'hF);
      chk("rst_seg", {24'd0, io_seg}, 32'hFF);
      chk("rst_tick", {31'd0, frame_tick}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      check_outputs();

      // Free scan with nothing loaded.
      idle(70);

      // Single load: digit 0 pattern 3F with its decimal point.
      t0 = t;
      cycle(1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001);
      tgt = ((t0 + 1) / FRAME + 1) * FRAME + BC;
      while (t < tgt) idle(1);
      chk("dig0_lit", {24'd0, io_seg}, 32'h40);
      chk("dig0_sel", {28'd0, io_sel}, 32'hE);

      // Two loads in one frame; only the second is ever shown.
      while ((t % FRAME) != 3) idle(1);
      cycle(1'b1, {7'h00, 7'h00, 7'h06, 7'h00}, 4'b0000);
      idle(5);
      cycle(1'b1, {7'h00, 7'h00, 7'h5B, 7'h00}, 4'b0000);
      tgt = (t / FRAME + 1) * FRAME + DC + BC;
      while (t < tgt) idle(1);
      chk("dig1_lit", {24'd0, io_seg}, 32'hA4);

      // Load on the boundary cycle after an earlier load in the same frame.
      idle(3);
      cycle(1'b1, {7'h11, 7'h22, 7'h33, 7'h44}, 4'b1010);
      while ((t % FRAME) != FRAME - 1) idle(1);
      cycle(1'b1, {7'h55, 7'h66, 7'h77, 7'h08}, 4'b0101);
      idle(2 * FRAME + 4);

      rand_run(500);

      // Asynchronous reset in the middle of digit 2's ON phase.
      while (!(((t / DC) % 4) == 2 && (t % DC) >= BC + 1)) cycle(1'b1, 28'($urandom), 4'($urandom));
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_sel", {28'd0, io_sel}, 32'hF);
      chk("async_seg", {24'd0, io_seg}, 32'hFF);
      @(posedge clk);
      #1;
      chk("hold_sel", {28'd0, io_sel}, 32'hF);
      chk("hold_tick", {31'd0, frame_tick}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lq.delete();
      t = 0;
      check_outputs();
      idle(2);
      chk("first_lit", {28'd0, io_sel}, 32'hE);
      chk("lost_load", {24'd0, io_seg}, 32'hFF);

      rand_run(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIGIT_CYCLES, default 25000, clock cycles per digit slot (legal: at least BLANK_CYCLES+1).
REQ-002 Parameter BLANK_CYCLES, default 100, cycles at the start of each slot with all digits off (anti-ghosting; legal: at least 1).
REQ-003 clk  input  1  100 MHz system clock; all state is on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 seg0..seg3  input  7 each  active-high segment patterns for digits 0..3; bit0=a .. bit6=g.
REQ-006 dp  input  4  active-high decimal points; dp[k] belongs to digit k.
REQ-007 load  input  1  single-cycle strobe that captures seg0..seg3 and dp into the shadow registers.
REQ-008 io_sel  output  4  active-low digit enables; io_sel[k]=0 lights digit k.
REQ-009 io_seg  output  8  active-low segments; io_seg[6:0]=a..g, io_seg[7]=dp.
REQ-010 frame_tick  output  1  one-cycle pulse on the frame-boundary cycle.

Function
REQ-011 A slot counter shall count 0..DIGIT_CYCLES-1 and wrap; on wrap, the digit index shall advance 0->1->2->3->0.
REQ-012 The FSM shall have two states, BLANK and ON: BLANK for counter 0..BLANK_CYCLES-1, then ON for the rest of the slot.
REQ-013 In BLANK, io_sel shall be 4'hF and io_seg shall be 8'hFF.
REQ-014 In ON, io_sel shall have exactly one bit low (the current index) and io_seg shall be the bitwise inverse of {disp_dp[idx], disp_seg[idx]}.
REQ-015 io_sel and io_seg shall be registered outputs, with no combinational path from any input.
REQ-016 When load=1, seg0..seg3 and dp shall be written into the shadow registers and the pending flag shall be set.
REQ-017 The frame boundary is the last cycle of digit 3's slot: frame_tick shall be 1 on that cycle; if pending=1, the display registers shall take the shadow contents and pending shall clear.
REQ-018 load on the boundary cycle itself: the old shadow shall transfer, the new data shall be captured, and pending shall stay 1 (the new data is shown the following frame).
REQ-019 Multiple loads within one frame: the last one wins; earlier ones are never displayed.
REQ-020 New data shall first appear on the first ON cycle of digit 0 after the boundary; the display shall never show a mix of two loads within one frame.
REQ-021 Without any load, the display registers shall hold their contents indefinitely.

Reset
REQ-022 While rst_n=0: io_sel=4'hF, io_seg=8'hFF, frame_tick=0, slot counter=0, index=0, state=BLANK, pending=0, shadow and display registers all 0.
REQ-023 Reset asserted mid-slot shall blank the outputs immediately (asynchronously); after release, scanning shall restart at digit 0, counter 0, and any pending load shall be lost.

Configuration
REQ-024 Macro SEG7_SCAN_DIM_EN: when defined, it adds input dim (3 bits) and a free-running 3-bit PWM counter; in ON, the digit shall be enabled only on cycles where pwm_cnt <= dim, otherwise the outputs shall be as in BLANK.
REQ-025 At dim=7, on-time is 100% of ON; at dim=0, it is 1/8.
REQ-026 Without the macro: the dim port and PWM logic shall be absent, and ON shall drive the digit every cycle.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2)
REQ-027 Reset release, no load -> io_sel cycles 4'hE,4'hD,4'hB,4'h7 for 6 cycles each, separated by 2-cycle 4'hF gaps; io_seg stays 8'hFF; frame_tick occurs every 32 cycles.
REQ-028 load with seg0=7'h3F, dp=4'b0001, other patterns 0 -> after the next frame_tick, digit-0 ON shows io_seg=8'h40 and digits 1..3 show 8'hFF.
REQ-029 Two loads in one frame (seg1=7'h06, then 7'h5B) -> only 7'h5B is displayed; digit 1 shows io_seg=8'hA4.
REQ-030 load on the frame_tick cycle -> the old shadow is shown next frame and the new data one frame later.
REQ-031 rst_n dropped mid-ON of digit 2 -> outputs go to 4'hF/8'hFF the same cycle; after release, the first lit digit is digit 0, 2 cycles later.
REQ-032 SEG7_SCAN_DIM_EN defined, dim=3 -> digit lit on exactly 4 of every 8 ON cycles; dim=7 -> lit for all 6 ON cycles.
